dmem_responder: RTL and testbench

Data-memory responder at the MEM-stage end of the pipeline; it answers the load/store requests that the EXE/MEM pipeline register presents (ALU result as address, DRAM write enable, store data). It holds a word-organised data RAM and performs byte/half/word accesses with sign or zero extension after a programmable number of wait states. While an access is in progress it raises `stall_o` to freeze the upstream pipeline, and it reports misaligned or illegal accesses through `err_o`.

---
 rtl/dmem_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// MEM-stage data-memory responder. Accepts one load/store request at a time
// from the EXE/MEM register, waits WAIT_CYCLES extra cycles, then performs a
// byte/half/word access on a word-organised RAM. Loads are sign- or
// zero-extended. Misaligned or unsupported requests get an error response
// without touching the RAM.
//
// Ports:
//   clk       in   1  clock, rising edge
//   rst       in   1  asynchronous reset, active-low
//   req_i     in   1  access request (held with operands while stall_o=1)
//   we_i      in   1  1 = store, 0 = load
//   addr_i    in  32  byte address
//   wdata_i   in  32  store data ([7:0] for SB, [15:0] for SH)
//   funct3_i  in   3  RV32I width/extension code
//   stall_o   out  1  freeze upstream stages
//   valid_o   out  1  one-cycle response strobe
//   rdata_o   out 32  extended load data (0 for stores and errors)
//   err_o     out  1  response is an error, qualified by valid_o
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            valid_q, valid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [AW-1:0]   idx;
    logic            access;
    logic [3:0]      be;
    logic [31:0]     wlanes;

    // Address bits above the RAM index are deliberately ignored (wrap-around).
    logic unused_addr;
    assign unused_addr = ^addr_i[31:AW+2];

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {a, 3'b000});
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] r;
        case (f3)
            3'b000:  r = 4'b0001 << a;
            3'b001:  r = a[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Replicate the store data so every lane carries the value it would need;
    // the byte enables then pick which lanes actually get written.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {4{d[7:0]}};
            3'b001:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    assign idx    = addr_q[AW+1:2];
    assign access = (state_q == BUSY) && (cnt_q == 4'd0);
    assign be     = byte_en(f3_q, addr_q[1:0]);
    assign wlanes = store_lanes(f3_q, wdata_q);

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        stall_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    stall_o = 1'b1;
                    if (req_legal(we_i, funct3_i, addr_i[1:0])) begin
                        we_d    = we_i;
                        addr_d  = addr_i[AW+1:0];
                        wdata_d = wdata_i;
                        f3_d    = funct3_i;
                        cnt_d   = WAIT_INIT;
                        state_d = BUSY;
                    end else begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : load_extend(f3_q, addr_q[1:0], mem_q[idx]);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // RAM write port. Contents are not reset; gating on rst keeps a store
    // from landing on an edge where reset is being held.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (access && we_q && rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// Testbench for dmem_responder. Two instances: u_a with WAIT_CYCLES=1 for the
// functional sequence, u_b with WAIT_CYCLES=3 for the reset-abort case.
// Expected responses are queued when a request is driven and compared when
// the DUT strobes valid_o.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, req_a, we_a, stall_a, valid_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [2:0]  f3_a;

    logic        rst_b, req_b, we_b, stall_b, valid_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [2:0]  f3_b;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst(rst_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
        .wdata_i(wdata_a), .funct3_i(f3_a), .stall_o(stall_a),
        .valid_o(valid_a), .rdata_o(rdata_a), .err_o(err_a)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_b (
        .clk(clk), .rst(rst_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
        .wdata_i(wdata_b), .funct3_i(f3_b), .stall_o(stall_b),
        .valid_o(valid_b), .rdata_o(rdata_b), .err_o(err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [32:0] e_a, e_b;
    logic        prev_va = 1'b0;
    logic        prev_vb = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitors: pop expected {err, rdata} on every valid strobe.
    always @(negedge clk) begin
        if (valid_a) begin
            if (prev_va) check("a_valid_back_to_back", 32'd1, 32'd0);
            if (q_a.size() == 0) begin
                check("a_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                check("a_rdata", rdata_a, e_a[31:0]);
                check("a_err", 32'(err_a), 32'(e_a[32]));
            end
        end
        prev_va = valid_a;
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (prev_vb) check("b_valid_back_to_back", 32'd1, 32'd0);
            if (q_b.size() == 0) begin
                check("b_unexpected_resp", 32'd1, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                check("b_rdata", rdata_b, e_b[31:0]);
                check("b_err", 32'(err_b), 32'(e_b[32]));
            end
        end
        prev_vb = valid_b;
    end

    // Drive one request, hold it while stalled, count stall cycles until the
    // response strobe. sel=0 -> u_a, sel=1 -> u_b.
    task automatic do_req(input bit sel, input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rdata, input int exp_stall);
        int stalls;
        bit got;
        stalls = 0;
        got    = 1'b0;
        @(posedge clk);
        #1;
        if (!sel) begin
            req_a = 1'b1; we_a = we; f3_a = f3; addr_a = addr; wdata_a = wdata;
            q_a.push_back({exp_err, exp_rdata});
        end else begin
            req_b = 1'b1; we_b = we; f3_b = f3; addr_b = addr; wdata_b = wdata;
            q_b.push_back({exp_err, exp_rdata});
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (sel ? stall_b : stall_a) stalls++;
            if (sel ? valid_b : valid_a) got = 1'b1;
        end
        if (!sel) req_a = 1'b0; else req_b = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    endtask

    int vcount;

    initial begin
        rst_a = 1'b0; req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; f3_a = '0;
        rst_b = 1'b0; req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; f3_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        @(negedge clk);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_stall", 32'(stall_a), 32'd0);
        check("rst_b_valid", 32'(valid_b), 32'd0);

        // Word store and loads of every width over the same word.
        do_req(0, "sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 3);
        do_req(0, "lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3);
        do_req(0, "lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 3);
        do_req(0, "lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h000000DE, 3);
        do_req(0, "lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFFBEEF, 3);
        do_req(0, "lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, 3);

        // Byte store: upper data bits must not leak into other lanes.
        do_req(0, "sb_11",  1'b1, 3'b000, 32'h11, 32'hAABBCC55, 1'b0, 32'h0, 3);
        do_req(0, "lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 3);
        @(negedge clk);
        check("rdata_hold", rdata_a, 32'hDEAD55EF);
        check("valid_single", 32'(valid_a), 32'd0);
        do_req(0, "lw_wrap", 1'b0, 3'b010, 32'h1010, 32'h0, 1'b0, 32'hDEAD55EF, 3);

        // Illegal requests: immediate error, rdata cleared, one stall cycle.
        do_req(0, "lw_mis",   1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1);
        do_req(0, "sh_mis",   1'b1, 3'b001, 32'h13, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
        do_req(0, "f3_011",   1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1);
        do_req(0, "st_f3_100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
        do_req(0, "lw_unchg", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 3);

        // Upper half store.
        do_req(0, "sh_12",  1'b1, 3'b001, 32'h12, 32'h99991234, 1'b0, 32'h0, 3);
        do_req(0, "lw_10c", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h123455EF, 3);

        // WAIT_CYCLES=3: known contents, then a store aborted by reset.
        do_req(1, "b_sw_init", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, 5);
        @(posedge clk);
        #1;
        req_b = 1'b1; we_b = 1'b1; f3_b = 3'b010; addr_b = 32'h20; wdata_b = 32'h12345678;
        @(negedge clk);
        check("b_abort_req_stall", 32'(stall_b), 32'd1);
        @(posedge clk);
        #1;
        req_b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        check("b_abort_stall", 32'(stall_b), 32'd0);
        check("b_abort_valid", 32'(valid_b), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        vcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_b) vcount++;
            if (stall_b) vcount++;
        end
        check("b_abort_idle", 32'(vcount), 32'd0);
        do_req(1, "b_lw_after", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 5);

        repeat (2) @(negedge clk);
        check("a_queue_empty", 32'(q_a.size()), 32'd0);
        check("b_queue_empty", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
